// File: rtl/simd_result_collector_if.sv
// simd_result_collector_if: result return channel toward the memory controller (valid/ready)
interface simd_result_collector_if #(parameter int W = 128);
    logic [W-1:0] mc_data_out_res;
    logic [W-1:0] mc_data_out_extra;
    logic mc_valid;
    logic mc_ready;
    modport master (output mc_data_out_res, mc_data_out_extra, mc_valid, input mc_ready);
    modport slave (input mc_data_out_res, mc_data_out_extra, mc_valid, output mc_ready);
endinterface

// File: rtl/simd_result_collector.sv
// simd_result_collector: captures per-lane results into a FIFO and returns them over valid/ready
module simd_result_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int LANE_W = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [5:0] data_size,
    input  logic res_valid,
    input  logic [LANE_W-1:0] out_procc0,
    input  logic [LANE_W-1:0] out_procc1,
    input  logic [LANE_W-1:0] out_procc2,
    input  logic [LANE_W-1:0] out_procc3,
    input  logic [LANE_W-1:0] out_extra_procc0,
    input  logic [LANE_W-1:0] out_extra_procc1,
    input  logic [LANE_W-1:0] out_extra_procc2,
    input  logic [LANE_W-1:0] out_extra_procc3,
    simd_result_collector_if.master mc,
    output logic busy,
    output logic done,
    output logic overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 4 * LANE_W;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    state_t state;
    logic [2*DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [5:0] len, cnt;
    logic push_req, pop, push;
    assign push_req = state == COLLECT && res_valid;
    assign pop = mc.mc_valid && mc.mc_ready;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign push = push_req && (count != FULL || pop);
    assign mc.mc_valid = count != '0;
    assign {mc.mc_data_out_extra, mc.mc_data_out_res} = mem[rd_ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            len <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {out_extra_procc3, out_extra_procc2, out_extra_procc1, out_extra_procc0,
                                out_procc3, out_procc2, out_procc1, out_procc0};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push_req) cnt <= cnt + 6'd1;
            if (push_req && !push) overflow <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    len <= data_size;
                    cnt <= '0;
                    overflow <= 1'b0;
                    busy <= 1'b1;
                    state <= data_size == '0 ? DRAIN : COLLECT;
                end
                COLLECT: if (push_req && cnt + 6'd1 == len) state <= DRAIN;
                DRAIN: if (count == '0 || (count == 1 && pop)) begin
                    state <= DONE;
                    done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simd_result_collector.sv
// tb_simd_result_collector: table vectors, directed corner sequences and a random run against a queue model
module tb_simd_result_collector;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [5:0] data_size = '0;
    logic res_valid = 1'b0;
    logic [31:0] op0, op1, op2, op3, ex0, ex1, ex2, ex3;
    logic busy, done, overflow;
    int total = 0;
    int passes = 0;
    simd_result_collector_if mc();
    simd_result_collector dut (
        .clk(clk), .reset(reset), .start(start), .data_size(data_size), .res_valid(res_valid),
        .out_procc0(op0), .out_procc1(op1), .out_procc2(op2), .out_procc3(op3),
        .out_extra_procc0(ex0), .out_extra_procc1(ex1), .out_extra_procc2(ex2), .out_extra_procc3(ex3),
        .mc(mc), .busy(busy), .done(done), .overflow(overflow)
    );
    always #5 clk = ~clk;

    // reference: phase 0 idle, 1 collecting, 2 draining, 3 done
    int m_phase = 0;
    int m_len = 0;
    int m_cnt = 0;
    bit m_ovf = 0;
    logic [255:0] m_q[$];

    task automatic chk(string n, logic [127:0] a, logic [127:0] e);
        total++;
        if (a === e) passes++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    function automatic logic [127:0] beat_res(int k);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = 32'(32'h11111111 * (4 * k + i + 1));
        return r;
    endfunction

    task automatic set_beat(int k);
        {op3, op2, op1, op0} = beat_res(k);
        {ex3, ex2, ex1, ex0} = ~beat_res(k);
    endtask

    function automatic void model_edge();
        bit pop = m_q.size() != 0 && mc.mc_ready;
        bit cap = m_phase == 1 && res_valid;
        int nxt = m_phase;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (m_q.size() < 4) m_q.push_back({ex3, ex2, ex1, ex0, op3, op2, op1, op0});
            else m_ovf = 1;
            m_cnt++;
        end
        case (m_phase)
            0: if (start) begin
                m_len = int'(data_size);
                m_cnt = 0;
                m_ovf = 0;
                nxt = data_size == 0 ? 2 : 1;
            end
            1: if (cap && m_cnt == m_len) nxt = 2;
            2: if (m_q.size() == 0) nxt = 3;
            default: nxt = 0;
        endcase
        m_phase = nxt;
    endfunction

    task automatic model_check();
        logic [255:0] h;
        chk("model_valid", 128'(mc.mc_valid), 128'(m_q.size() != 0));
        chk("model_busy", 128'(busy), 128'(m_phase != 0));
        chk("model_done", 128'(done), 128'(m_phase == 3));
        chk("model_overflow", 128'(overflow), 128'(m_ovf));
        if (m_q.size() != 0) begin
            h = m_q[0];
            chk("model_res", mc.mc_data_out_res, h[127:0]);
            chk("model_extra", mc.mc_data_out_extra, h[255:128]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic job_start(int ds, logic rdy);
        start = 1'b1;
        data_size = 6'(ds);
        res_valid = 1'b0;
        mc.mc_ready = rdy;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(int k);
        set_beat(k);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic drain_check(int first, int n);
        mc.mc_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_head", mc.mc_data_out_res, beat_res(first + i));
            tick();
        end
        chk("drain_done", 128'(done), 128'(1));
        tick();
    endtask

    typedef struct {
        logic st;
        logic [5:0] ds;
        logic rv;
        int bt;
        logic rdy;
        logic ev;
        logic [127:0] eres;
        logic eb;
        logic ed;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 6'd2, 1'b0, 0, 1'b1, 1'b0, '0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 6'd0, 1'b1, 0, 1'b1, 1'b1, 128'h44444444_33333333_22222222_11111111, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 6'd0, 1'b1, 1, 1'b1, 1'b1, 128'h88888888_77777777_66666666_55555555, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 6'd0, 1'b0, 0, 1'b1, 1'b0, '0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 6'd0, 1'b0, 0, 1'b1, 1'b0, '0, 1'b0, 1'b0};
        mc.mc_ready = 1'b0;
        set_beat(0);
        #22;
        chk("rst_valid", 128'(mc.mc_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_res", mc.mc_data_out_res, 128'(0));
        chk("rst_extra", mc.mc_data_out_extra, 128'(0));
        reset = 1'b0;
        tick();
        // basic job from the vector table
        for (int i = 0; i < 5; i++) begin
            start = tbl[i].st;
            data_size = tbl[i].ds;
            res_valid = tbl[i].rv;
            set_beat(tbl[i].bt);
            mc.mc_ready = tbl[i].rdy;
            tick();
            chk("tbl_valid", 128'(mc.mc_valid), 128'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_res", mc.mc_data_out_res, tbl[i].eres);
            if (tbl[i].ev) chk("tbl_extra", mc.mc_data_out_extra, ~tbl[i].eres);
            chk("tbl_busy", 128'(busy), 128'(tbl[i].eb));
            chk("tbl_done", 128'(done), 128'(tbl[i].ed));
        end
        start = 1'b0;
        res_valid = 1'b0;
        // backpressure: head must hold while not accepted
        job_start(4, 1'b0);
        for (int k = 0; k < 4; k++) beat(k);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_valid", 128'(mc.mc_valid), 128'(1));
            chk("bp_head", mc.mc_data_out_res, beat_res(0));
        end
        chk("bp_overflow", 128'(overflow), 128'(0));
        drain_check(0, 4);
        // overflow: beats 5 and 6 dropped
        job_start(6, 1'b0);
        for (int k = 0; k < 6; k++) beat(k);
        chk("ovf_flag", 128'(overflow), 128'(1));
        chk("ovf_busy", 128'(busy), 128'(1));
        drain_check(0, 4);
        // full with simultaneous pop keeps four entries
        job_start(6, 1'b0);
        for (int k = 0; k < 4; k++) beat(k);
        mc.mc_ready = 1'b1;
        beat(4);
        mc.mc_ready = 1'b0;
        chk("fullpop_head", mc.mc_data_out_res, beat_res(1));
        chk("fullpop_no_ovf", 128'(overflow), 128'(0));
        beat(5);
        chk("fullpop_still_full", 128'(overflow), 128'(1));
        drain_check(1, 4);
        // zero length
        job_start(0, 1'b1);
        chk("zero_valid", 128'(mc.mc_valid), 128'(0));
        chk("zero_done1", 128'(done), 128'(0));
        tick();
        chk("zero_done2", 128'(done), 128'(1));
        chk("zero_valid2", 128'(mc.mc_valid), 128'(0));
        tick();
        chk("zero_idle", 128'(busy), 128'(0));
        // reset mid-job with three entries buffered
        job_start(5, 1'b0);
        for (int k = 0; k < 3; k++) beat(k);
        reset = 1'b1;
        #1;
        m_q.delete();
        m_phase = 0;
        m_ovf = 0;
        chk("midrst_valid", 128'(mc.mc_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_overflow", 128'(overflow), 128'(0));
        @(posedge clk);
        #2;
        reset = 1'b0;
        job_start(1, 1'b1);
        beat(7);
        chk("post_rst_head", mc.mc_data_out_res, beat_res(7));
        tick();
        chk("post_rst_done", 128'(done), 128'(1));
        tick();
        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start = $urandom_range(0, 7) == 0;
            data_size = 6'($urandom_range(0, 9));
            res_valid = 1'($urandom_range(0, 1));
            mc.mc_ready = $urandom_range(0, 3) != 0;
            {op3, op2, op1, op0} = {$urandom, $urandom, $urandom, $urandom};
            {ex3, ex2, ex1, ex0} = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
